// File: rtl/tone_pkg.sv
// Shared definitions for the buzzer tone path: note codes, table entry layout
// and the duration prescaler divisor.
package tone_pkg;

    localparam int unsigned NOTE_W_DEF    = 4;
    localparam int unsigned DUR_W_DEF     = 8;
    localparam int unsigned REST_CODE_DEF = 8;

    localparam logic [NOTE_W_DEF-1:0] NOTE_C4   = 4'd0;
    localparam logic [NOTE_W_DEF-1:0] NOTE_D4   = 4'd1;
    localparam logic [NOTE_W_DEF-1:0] NOTE_E4   = 4'd2;
    localparam logic [NOTE_W_DEF-1:0] NOTE_F4   = 4'd3;
    localparam logic [NOTE_W_DEF-1:0] NOTE_G4   = 4'd4;
    localparam logic [NOTE_W_DEF-1:0] NOTE_A4   = 4'd5;
    localparam logic [NOTE_W_DEF-1:0] NOTE_B4   = 4'd6;
    localparam logic [NOTE_W_DEF-1:0] NOTE_REST = 4'd8;

    typedef struct packed {
        logic [NOTE_W_DEF-1:0] note;
        logic [DUR_W_DEF-1:0]  dur;
    } tone_entry_t;

    // Clock cycles per duration tick
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control, table-write and note-output bundle between a host and tone_sequencer.
interface tone_sequencer_if #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned NOTE_W = 4,
    parameter int unsigned DUR_W  = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              start;
    logic              stop;
    logic              loop_en;
    logic [AW:0]       len;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [NOTE_W-1:0] wr_note;
    logic [DUR_W-1:0]  wr_dur;
    logic [NOTE_W-1:0] note;
    logic [AW-1:0]     step;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, loop_en, len, wr_en, wr_addr, wr_note, wr_dur,
        input  note, step, busy, done
    );

    modport slave (
        input  start, stop, loop_en, len, wr_en, wr_addr, wr_note, wr_dur,
        output note, step, busy, done
    );

endinterface

// File: rtl/tone_tick_gen.sv
// Duration prescaler: counts 0..DIV-1 and flags the final count as a tick.
module tone_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Runtime-loadable note-sequence player: steps a (note, duration) table on a
// prescaled tick, with start/stop, one-shot or loop mode and a done pulse.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 4000000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned NOTE_W    = NOTE_W_DEF,
    parameter int unsigned DUR_W     = DUR_W_DEF,
    parameter int unsigned REST_CODE = REST_CODE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    tone_sequencer_if.slave  bus
);
    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [NOTE_W-1:0] REST = NOTE_W'(REST_CODE);

    if ((TICK_HZ == 0) || (CLK_HZ % TICK_HZ != 0) || (DIV < 2)) begin : g_bad_div
        $error("tone_sequencer: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("tone_sequencer: DEPTH must be a power of two >= 2");
    end

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state_q;
    logic [NOTE_W-1:0] note_q;
    logic [AW-1:0]     step_q;
    logic              busy_q;
    logic              done_q;
    logic [DUR_W-1:0]  rem_q;
    logic [AW:0]       len_q;

    logic [NOTE_W-1:0] tbl_note [DEPTH];
    logic [DUR_W-1:0]  tbl_dur  [DEPTH];

    logic              tick;
    logic              start_ok_c;
    logic              more_c;
    logic [AW-1:0]     nxt_idx_c;
    logic [NOTE_W-1:0] ld_note_c;
    logic [DUR_W-1:0]  ld_dur_c;
    logic              clr_c;

    // Table storage; the read side is combinational so a same-edge write is not seen by a load
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            tbl_note[bus.wr_addr] <= bus.wr_note;
            tbl_dur[bus.wr_addr]  <= bus.wr_dur;
        end
    end

    always_comb begin
        start_ok_c = bus.start && (bus.len != '0);
        more_c     = (({1'b0, step_q} + (AW+1)'(1)) < len_q);
        nxt_idx_c  = '0;
        if ((state_q == PLAY) && !start_ok_c && more_c) begin
            nxt_idx_c = step_q + AW'(1);
        end
        ld_note_c = tbl_note[nxt_idx_c];
        ld_dur_c  = (tbl_dur[nxt_idx_c] == '0) ? DUR_W'(1) : tbl_dur[nxt_idx_c];
        clr_c     = (state_q == IDLE) || bus.stop || start_ok_c;
    end

    tone_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_c),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            note_q  <= REST;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            len_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok_c) begin
                        state_q <= PLAY;
                        busy_q  <= 1'b1;
                        step_q  <= '0;
                        note_q  <= ld_note_c;
                        rem_q   <= ld_dur_c;
                        len_q   <= bus.len;
                    end
                end
                PLAY: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        note_q  <= REST;
                        step_q  <= '0;
                    end else if (start_ok_c) begin
                        step_q <= '0;
                        note_q <= ld_note_c;
                        rem_q  <= ld_dur_c;
                        len_q  <= bus.len;
                    end else if (tick) begin
                        if (rem_q > DUR_W'(1)) begin
                            rem_q <= rem_q - DUR_W'(1);
                        end else if (more_c || bus.loop_en) begin
                            step_q <= nxt_idx_c;
                            note_q <= ld_note_c;
                            rem_q  <= ld_dur_c;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            note_q  <= REST;
                            step_q  <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.note = note_q;
    assign bus.step = step_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
